// File: rtl/ecc_secded_pipe.sv
// Two-stage SECDED check/correct pipeline with status counters and a first-error log.
// Latency 2 cycles, 1 word/cycle; in_ready drops only when both stages hold words and out_ready is low.
module ecc_secded_pipe #(
  parameter int DATA_WIDTH   = 54,
  parameter int PARITY_WIDTH = 7,
  parameter int TAG_WIDTH    = 8,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [PARITY_WIDTH-1:0] in_parity,
  input  logic [TAG_WIDTH-1:0]    in_tag,
  input  logic                    in_bypass,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [PARITY_WIDTH-1:0] out_parity,
  output logic [TAG_WIDTH-1:0]    out_tag,
  output logic [PARITY_WIDTH-1:0] out_syndrome,
  output logic                    out_sbit_err,
  output logic                    out_dbit_err,
  output logic [COUNT_WIDTH-1:0]  sbit_cnt,
  output logic [COUNT_WIDTH-1:0]  dbit_cnt,
  input  logic                    cnt_clr,
  output logic                    log_valid,
  output logic [TAG_WIDTH-1:0]    log_tag,
  output logic [PARITY_WIDTH-1:0] log_syndrome,
  input  logic                    log_clr
);

  localparam int LOW_W = PARITY_WIDTH - 1;
  localparam logic [PARITY_WIDTH-1:0] SYN_ONE = {{(PARITY_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [COUNT_WIDTH-1:0]  CNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  typedef logic [DATA_WIDTH-1:0][PARITY_WIDTH-1:0] hmat_t;

  // Column idx: idx-th non-power-of-two >= 3 in the low bits, MSB forces odd weight.
  function automatic logic [PARITY_WIDTH-1:0] h_col(input int idx);
    logic [PARITY_WIDTH-1:0] col;
    int n;
    col = '0;
    n   = 0;
    for (int v = 3; v < (1 << LOW_W); v++) begin
      if ((v & (v - 1)) != 0) begin
        if (n == idx) begin
          col[LOW_W-1:0] = v[LOW_W-1:0];
          col[LOW_W]     = ~^v[LOW_W-1:0];
        end
        n++;
      end
    end
    return col;
  endfunction

  function automatic hmat_t build_h();
    hmat_t m;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      m[i] = h_col(i);
    end
    return m;
  endfunction

  localparam hmat_t H = build_h();

  function automatic logic [PARITY_WIDTH-1:0] encode(input logic [DATA_WIDTH-1:0] d);
    logic [PARITY_WIDTH-1:0] p;
    p = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (d[i]) p = p ^ H[i];
    end
    return p;
  endfunction

  typedef struct packed {
    logic [DATA_WIDTH-1:0]   data;
    logic [TAG_WIDTH-1:0]    tag;
    logic                    bypass;
    logic [PARITY_WIDTH-1:0] syn;
  } s1_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]   data;
    logic [PARITY_WIDTH-1:0] parity;
    logic [TAG_WIDTH-1:0]    tag;
    logic [PARITY_WIDTH-1:0] syn;
    logic                    sbit;
    logic                    dbit;
  } s2_t;

  logic                  s1_valid;
  logic                  s2_valid;
  logic                  s1_adv;
  logic                  out_hs;
  s1_t                   s1_q;
  s1_t                   s1_d;
  s2_t                   s2_q;
  s2_t                   s2_d;
  logic [DATA_WIDTH-1:0] fixed_data;
  logic                  col_hit;
  logic                  syn_onehot;

  assign s1_adv   = !s2_valid || out_ready;
  assign in_ready = !s1_valid || s1_adv;
  assign out_hs   = s2_valid && out_ready;

  always_comb begin
    s1_d        = '0;
    s1_d.data   = in_data;
    s1_d.tag    = in_tag;
    s1_d.bypass = in_bypass;
    s1_d.syn    = in_parity ^ encode(in_data);
  end

  // Columns all have odd weight, so a zero syndrome can never match one.
  always_comb begin
    fixed_data = s1_q.data;
    col_hit    = 1'b0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (s1_q.syn == H[i]) begin
        fixed_data[i] = ~s1_q.data[i];
        col_hit       = 1'b1;
      end
    end
  end

  assign syn_onehot = (s1_q.syn != '0) && ((s1_q.syn & (s1_q.syn - SYN_ONE)) == '0);

  always_comb begin
    s2_d     = '0;
    s2_d.tag = s1_q.tag;
    if (s1_q.bypass) begin
      s2_d.data = s1_q.data;
    end else begin
      s2_d.data = fixed_data;
      s2_d.syn  = s1_q.syn;
      s2_d.sbit = col_hit || syn_onehot;
      s2_d.dbit = (s1_q.syn != '0) && !col_hit && !syn_onehot;
    end
    s2_d.parity = encode(s2_d.data);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
      s2_valid <= 1'b0;
      s2_q     <= '0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) s1_q <= s1_d;
      end
      if (s1_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_q <= s2_d;
      end
    end
  end

  // A clear in the same cycle as a flagged handshake drops that event.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      sbit_cnt <= '0;
      dbit_cnt <= '0;
    end else if (out_hs) begin
      if (s2_q.sbit && (sbit_cnt != '1)) sbit_cnt <= sbit_cnt + CNT_ONE;
      if (s2_q.dbit && (dbit_cnt != '1)) dbit_cnt <= dbit_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      log_valid    <= 1'b0;
      log_tag      <= '0;
      log_syndrome <= '0;
    end else if (out_hs && s2_q.dbit && (!log_valid || log_clr)) begin
      log_valid    <= 1'b1;
      log_tag      <= s2_q.tag;
      log_syndrome <= s2_q.syn;
    end else if (log_clr) begin
      log_valid <= 1'b0;
    end
  end

  assign out_valid    = s2_valid;
  assign out_data     = s2_q.data;
  assign out_parity   = s2_q.parity;
  assign out_tag      = s2_q.tag;
  assign out_syndrome = s2_q.syn;
  assign out_sbit_err = s2_q.sbit;
  assign out_dbit_err = s2_q.dbit;

endmodule

// File: tb/tb_ecc_secded_pipe.sv
// Directed and random stimulus for ecc_secded_pipe, scored against a word-level queue model.
module tb_ecc_secded_pipe;

  localparam int DW = 54;
  localparam int PW = 7;
  localparam int TW = 8;
  localparam int CW = 2;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [PW-1:0] in_parity;
  logic [TW-1:0] in_tag;
  logic          in_bypass;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [PW-1:0] out_parity;
  logic [TW-1:0] out_tag;
  logic [PW-1:0] out_syndrome;
  logic          out_sbit_err;
  logic          out_dbit_err;
  logic [CW-1:0] sbit_cnt;
  logic [CW-1:0] dbit_cnt;
  logic          cnt_clr;
  logic          log_valid;
  logic [TW-1:0] log_tag;
  logic [PW-1:0] log_syndrome;
  logic          log_clr;

  always #5 clk = ~clk;

  ecc_secded_pipe #(
    .DATA_WIDTH(DW), .PARITY_WIDTH(PW), .TAG_WIDTH(TW), .COUNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_parity(in_parity),
    .in_tag(in_tag), .in_bypass(in_bypass),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_parity(out_parity),
    .out_tag(out_tag), .out_syndrome(out_syndrome), .out_sbit_err(out_sbit_err),
    .out_dbit_err(out_dbit_err),
    .sbit_cnt(sbit_cnt), .dbit_cnt(dbit_cnt), .cnt_clr(cnt_clr),
    .log_valid(log_valid), .log_tag(log_tag), .log_syndrome(log_syndrome), .log_clr(log_clr)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [PW-1:0] parity;
    logic [TW-1:0] tag;
    logic [PW-1:0] syn;
    logic          sb;
    logic          db;
    int            t;
  } exp_t;

  exp_t          q[$];
  logic [PW-1:0] cols[DW];
  int            n_assert = 0;
  int            n_fail = 0;
  int            cyc = 0;
  int            last_pop = -100;
  int            n_out = 0;
  int            m_scnt = 0;
  int            m_dcnt = 0;
  logic          m_lv = 1'b0;
  logic [TW-1:0] m_ltag = '0;
  logic [PW-1:0] m_lsyn = '0;
  logic          last_in_hs;

  logic          obs_rdy, obs_vld, obs_sb, obs_db, obs_lv;
  logic [DW-1:0] obs_data;
  logic [PW-1:0] obs_parity, obs_syn, obs_lsyn;
  logic [TW-1:0] obs_tag, obs_ltag;
  logic [CW-1:0] obs_scnt, obs_dcnt;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", name, obs, expv);
    end
  endtask

  function automatic logic [PW-1:0] ref_encode(input logic [DW-1:0] d);
    logic [PW-1:0] p = '0;
    for (int i = 0; i < DW; i++) if (d[i]) p = p ^ cols[i];
    return p;
  endfunction

  function automatic exp_t ref_word(input logic [DW-1:0] d, input logic [PW-1:0] p,
                                    input logic [TW-1:0] tag, input logic byp, input int t);
    exp_t e;
    int   idx = -1;
    e.data = d; e.tag = tag; e.t = t; e.sb = 1'b0; e.db = 1'b0;
    e.syn = byp ? '0 : (p ^ ref_encode(d));
    for (int i = 0; i < DW; i++) if (e.syn == cols[i]) idx = i;
    if (e.syn != '0) begin
      if (idx >= 0) begin
        e.data[idx] = ~e.data[idx];
        e.sb = 1'b1;
      end else if ($countones(e.syn) == 1) e.sb = 1'b1;
      else e.db = 1'b1;
    end
    e.parity = ref_encode(e.data);
    return e;
  endfunction

  // One clock: check everything against the model mid-cycle, then advance the model past the edge.
  task automatic cycle();
    logic exp_rdy, exp_vld, in_hs, out_hs;
    exp_t f;
    #2;
    exp_rdy = (q.size() < 2) || out_ready;
    exp_vld = (q.size() > 0) && (cyc >= q[0].t + 2) && (cyc > last_pop);
    obs_rdy = in_ready; obs_vld = out_valid; obs_data = out_data; obs_parity = out_parity;
    obs_tag = out_tag; obs_syn = out_syndrome; obs_sb = out_sbit_err; obs_db = out_dbit_err;
    obs_scnt = sbit_cnt; obs_dcnt = dbit_cnt; obs_lv = log_valid; obs_ltag = log_tag;
    obs_lsyn = log_syndrome;
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, exp_vld);
    if (exp_vld && out_valid === 1'b1) begin
      chk("out_data", out_data, q[0].data);
      chk("out_parity", out_parity, q[0].parity);
      chk("out_tag", out_tag, q[0].tag);
      chk("out_syndrome", out_syndrome, q[0].syn);
      chk("out_sbit_err", out_sbit_err, q[0].sb);
      chk("out_dbit_err", out_dbit_err, q[0].db);
    end
    chk("sbit_cnt", sbit_cnt, m_scnt);
    chk("dbit_cnt", dbit_cnt, m_dcnt);
    chk("log_valid", log_valid, m_lv);
    if (m_lv) begin
      chk("log_tag", log_tag, m_ltag);
      chk("log_syndrome", log_syndrome, m_lsyn);
    end
    if (out_valid === 1'b1 && out_ready && !rst) n_out++;
    in_hs  = in_valid && exp_rdy && !rst;
    out_hs = exp_vld && out_ready && !rst;
    last_in_hs = in_hs;
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
      last_pop = -100;
      m_scnt = 0; m_dcnt = 0; m_lv = 1'b0; m_ltag = '0; m_lsyn = '0;
    end else begin
      if (out_hs) begin
        f = q.pop_front();
        last_pop = cyc;
      end
      if (cnt_clr) begin
        m_scnt = 0; m_dcnt = 0;
      end else if (out_hs) begin
        if (f.sb && m_scnt < CNT_MAX) m_scnt++;
        if (f.db && m_dcnt < CNT_MAX) m_dcnt++;
      end
      if (out_hs && f.db && (!m_lv || log_clr)) begin
        m_lv = 1'b1; m_ltag = f.tag; m_lsyn = f.syn;
      end else if (log_clr) m_lv = 1'b0;
      if (in_hs) q.push_back(ref_word(in_data, in_parity, in_tag, in_bypass, cyc));
    end
    cyc++;
  endtask

  task automatic drive(input logic [DW-1:0] d, input logic [PW-1:0] p,
                       input logic [TW-1:0] tag, input logic byp);
    in_valid = 1'b1; in_data = d; in_parity = p; in_tag = tag; in_bypass = byp;
  endtask

  // Word handshake plus one idle cycle; the next cycle() is the output cycle.
  task automatic launch(input logic [DW-1:0] d, input logic [PW-1:0] p,
                        input logic [TW-1:0] tag, input logic byp);
    drive(d, p, tag, byp);
    cycle();
    in_valid = 1'b0; in_bypass = 1'b0;
    cycle();
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [PW-1:0] p,
                      input logic [TW-1:0] tag, input logic byp);
    launch(d, p, tag, byp);
    cycle();
  endtask

  task automatic gen_word(output logic [DW-1:0] d, output logic [PW-1:0] p);
    logic [63:0] r;
    int b1, b2;
    r = {$urandom(), $urandom()};
    d = r[DW-1:0];
    p = ref_encode(d);
    case ($urandom_range(4, 0))
      1: d[$urandom_range(DW-1, 0)] ^= 1'b1;
      2: p[$urandom_range(PW-1, 0)] ^= 1'b1;
      3: begin
        b1 = $urandom_range(DW-1, 0);
        b2 = (b1 + 1 + $urandom_range(DW-2, 0)) % DW;
        d[b1] ^= 1'b1;
        d[b2] ^= 1'b1;
      end
      4: p = PW'($urandom());
      default: ;
    endcase
  endtask

  initial begin
    logic [DW-1:0] d;
    logic [PW-1:0] p;
    logic [PW-2:0] lo;
    int k, sent, budget, out0;

    k = 0;
    for (int v = 3; k < DW; v++) begin
      if ($countones(v) != 1) begin
        lo = v[PW-2:0];
        cols[k] = {(($countones(v) % 2) == 0), lo};
        k++;
      end
    end

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_parity = '0; in_tag = '0; in_bypass = 1'b0;
    out_ready = 1'b1; cnt_clr = 1'b0; log_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    cycle();
    chk("reset_in_ready", obs_rdy, 1);
    chk("reset_out_valid", obs_vld, 0);
    chk("reset_out_data", obs_data, 0);
    chk("reset_out_syndrome", obs_syn, 0);
    chk("reset_flags", {obs_sb, obs_db, obs_lv}, 0);

    // Clean words.
    send('0, '0, 8'h01, 1'b0);
    chk("clean_data", obs_data, 0);
    chk("clean_parity", obs_parity, 0);
    chk("clean_flags", {obs_sb, obs_db}, 0);
    send(54'h1, 7'h43, 8'h02, 1'b0);
    chk("enc1_parity", obs_parity, 7'h43);
    chk("enc1_syn", obs_syn, 0);

    // Single data-bit errors.
    send(54'h1, '0, 8'h03, 1'b0);
    chk("sb0_syn", obs_syn, 7'b1000011);
    chk("sb0_data", obs_data, 0);
    chk("sb0_parity", obs_parity, 0);
    chk("sb0_sbit", obs_sb, 1);
    cycle();
    chk("sb0_cnt", obs_scnt, 1);
    d = '0; d[53] = 1'b1;
    send(d, '0, 8'h04, 1'b0);
    chk("sb53_syn", obs_syn, 7'b1111100);
    chk("sb53_data", obs_data, 0);

    // Check-bit and uncorrectable errors.
    send('0, 7'b0000001, 8'h05, 1'b0);
    chk("pb_sbit", obs_sb, 1);
    chk("pb_data", obs_data, 0);
    chk("pb_parity", obs_parity, 0);
    send(54'h3, '0, 8'hA5, 1'b0);
    chk("db_syn", obs_syn, 7'b0000110);
    chk("db_dbit", obs_db, 1);
    chk("db_data", obs_data, 3);
    cycle();
    chk("db_log_valid", obs_lv, 1);
    chk("db_log_tag", obs_ltag, 8'hA5);
    send('0, 7'b1111111, 8'h06, 1'b0);
    chk("unused_col_dbit", obs_db, 1);

    // Backpressure: fill both stages, then stream the rest with random stalls.
    out0 = n_out;
    out_ready = 1'b0;
    sent = 0;
    for (int i = 0; i < 3; i++) begin
      gen_word(d, p);
      drive(d, p, TW'(8'h10 + sent), 1'b0);
      cycle();
      if (last_in_hs) sent++;
    end
    chk("full_in_ready", obs_rdy, 0);
    budget = 0;
    while (sent < 6 && budget < 200) begin
      out_ready = $urandom_range(1, 0);
      cycle();
      if (last_in_hs) begin
        sent++;
        gen_word(d, p);
        drive(d, p, TW'(8'h10 + sent), 1'b0);
      end
      budget++;
    end
    in_valid = 1'b0;
    chk("stream_sent", sent, 6);
    for (int i = 0; i < 40; i++) begin
      out_ready = $urandom_range(1, 0);
      cycle();
    end
    out_ready = 1'b1;
    repeat (3) cycle();
    chk("stream_out_count", n_out - out0, 6);

    // Saturation and clears.
    cnt_clr = 1'b1;
    cycle();
    cnt_clr = 1'b0;
    cycle();
    chk("clr_sbit_cnt", obs_scnt, 0);
    chk("clr_dbit_cnt", obs_dcnt, 0);
    for (int i = 0; i < 5; i++) begin
      gen_word(d, p);
      p = ref_encode(d);
      d[i * 7] ^= 1'b1;
      send(d, p, TW'(8'h20 + i), 1'b0);
    end
    cycle();
    chk("sat_sbit_cnt", obs_scnt, 3);
    d = 54'h5A5A; p = ref_encode(d); d[9] ^= 1'b1;
    launch(d, p, 8'h30, 1'b0);
    cnt_clr = 1'b1;
    cycle();
    cnt_clr = 1'b0;
    chk("clr_hit_sbit", obs_sb, 1);
    cycle();
    chk("clr_wins_cnt", obs_scnt, 0);
    launch(54'hC0, ref_encode(54'hC0) ^ 7'h11, 8'h77, 1'b0);
    log_clr = 1'b1;
    cycle();
    log_clr = 1'b0;
    cycle();
    chk("logclr_valid", obs_lv, 1);
    chk("logclr_tag", obs_ltag, 8'h77);

    // Bypass.
    send(54'h1, '0, 8'h40, 1'b1);
    chk("byp_data", obs_data, 1);
    chk("byp_flags", {obs_sb, obs_db}, 0);
    chk("byp_syn", obs_syn, 0);
    chk("byp_parity", obs_parity, 7'h43);
    cycle();
    chk("byp_no_count", obs_scnt, 0);

    // Reset with both stages full.
    out_ready = 1'b0;
    drive(54'h11, '0, 8'h50, 1'b0);
    cycle();
    drive(54'h22, '0, 8'h51, 1'b0);
    cycle();
    in_valid = 1'b0;
    cycle();
    chk("prerst_out_valid", obs_vld, 1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    chk("rst_out_valid", obs_vld, 0);
    chk("rst_counts", {obs_scnt, obs_dcnt}, 0);
    chk("rst_log_valid", obs_lv, 0);
    chk("rst_in_ready", obs_rdy, 1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      gen_word(d, p);
      in_valid  = ($urandom_range(3, 0) != 0);
      in_data   = d;
      in_parity = p;
      in_tag    = TW'($urandom());
      in_bypass = ($urandom_range(7, 0) == 0);
      out_ready = ($urandom_range(3, 0) != 0);
      cnt_clr   = ($urandom_range(31, 0) == 0);
      log_clr   = ($urandom_range(15, 0) == 0);
      cycle();
    end
    in_valid = 1'b0; cnt_clr = 1'b0; log_clr = 1'b0; out_ready = 1'b1;
    repeat (4) cycle();
    chk("final_out_valid", obs_vld, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ecc_secded_pipe.md
Name: ecc_secded_pipe

Overview:
- Parametrised, pipelined SECDED check/correct stage for FIFO and RAM read paths; successor to the fixed 54/7 combinational calculator.
- Accepts a data word, its stored parity and a tag over a valid/ready handshake.
- Produces corrected data, freshly encoded parity, per-word error flags and the syndrome two cycles later.
- Keeps saturating error counters and a first-uncorrectable-error log for status registers.

Parameters:
- DATA_WIDTH, 54: data bits. Must satisfy DATA_WIDTH <= 2^(PARITY_WIDTH-1) - PARITY_WIDTH.
- PARITY_WIDTH, 7: check bits.
- TAG_WIDTH, 8: sideband tag (address/ID) carried alongside each word.
- COUNT_WIDTH, 16: width of each error counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept a word
- in_data  in  DATA_WIDTH  stored data
- in_parity  in  PARITY_WIDTH  stored check bits
- in_tag  in  TAG_WIDTH  sideband tag
- in_bypass  in  1  pass this word through uncorrected
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts
- out_data  out  DATA_WIDTH  corrected data
- out_parity  out  PARITY_WIDTH  encode(out_data)
- out_tag  out  TAG_WIDTH  tag of the output word
- out_syndrome  out  PARITY_WIDTH  syndrome of the word
- out_sbit_err  out  1  corrected single-bit error
- out_dbit_err  out  1  uncorrectable error
- sbit_cnt  out  COUNT_WIDTH  single-error count
- dbit_cnt  out  COUNT_WIDTH  uncorrectable-error count
- cnt_clr  in  1  clear both counters
- log_valid  out  1  error log holds an entry
- log_tag  out  TAG_WIDTH  tag of the first uncorrectable word
- log_syndrome  out  PARITY_WIDTH  syndrome of the first uncorrectable word
- log_clr  in  1  clear the error log

Behaviour:

Code definition:
- H-matrix column for data bit i:
  - Low PARITY_WIDTH-1 bits = the i-th integer >= 3 that is not a power of two, in ascending order.
  - MSB = 1 if the low part has even weight, so every column has odd weight.
- Parity bit j = XOR of the data bits whose column has bit j set.
- Syndrome = in_parity XOR encode(in_data).

Classification:
- Syndrome 0: clean.
- Syndrome equal to data column i: flip bit i, sbit_err=1.
- Syndrome of weight 1 (check-bit error): data unchanged, sbit_err=1.
- Any other nonzero syndrome, including even weight and unused odd-weight columns: data unchanged, dbit_err=1.

Pipeline:
- S1 registers data, tag, bypass and syndrome.
- S2 registers corrected data, out_parity, flags and syndrome.
- Latency is 2 cycles from the input handshake to out_valid. Throughput is 1 word/cycle when out_ready=1.
- in_ready = !s1_valid | s1_adv, where s1_adv = !s2_valid | out_ready. in_ready is combinational; there is no skid buffer.
- Output fields stay stable while out_valid=1 and out_ready=0.
- A word is never dropped or duplicated under any valid/ready pattern.

Bypass:
- Bypass travels with its word.
- For a bypassed word: out_data = in_data, sbit/dbit = 0, out_syndrome = 0, and it is not counted or logged.
- out_parity is still encode(out_data).

Counters:
- Update only on the output handshake (out_valid & out_ready).
- Increment by 1 per flagged word and saturate at all-ones.
- cnt_clr wins over a same-cycle increment; that event is lost.

Log:
- Captures out_tag and out_syndrome on the first dbit handshake while log_valid=0, then holds until log_clr.
- log_clr together with a dbit handshake in the same cycle: the new event is captured and log_valid stays 1.

Reset:
- Clears s1_valid, s2_valid, out_valid, counters, log_valid, log_tag, log_syndrome, out flags and out_syndrome to 0.
- Data registers are also cleared to 0.
- Reset mid-transfer discards in-flight words.
- in_ready is 1 in the cycle after reset deasserts.

Test Plan:
1. Clean word: in_data=0, in_parity=0, out_ready=1 -> after 2 cycles out_data=0, out_parity=0, sbit=dbit=0, counters 0. Also in_data=1 alone encodes to parity 7'h43.
2. Single data error: in_data=54'h1, in_parity=0 -> syndrome 7'b1000011, out_data=0, out_parity=0, sbit=1, sbit_cnt=1. Also in_data bit53 set, parity 0 -> syndrome 7'b1111100, bit 53 corrected.
3. Check-bit and double errors:
   - in_data=0, in_parity=7'b0000001 -> sbit=1, out_data=0, out_parity=0.
   - in_data=54'h3, parity 0 -> syndrome 7'b0000110, dbit=1, data unchanged, log_valid=1 with the tag.
   - Syndrome 7'b1111111 (unused column) -> dbit=1.
4. Backpressure: stream 6 words with random out_ready toggling -> every word appears once, in order, with fields stable while stalled. in_ready drops after 2 consecutive stall cycles with both stages full.
5. Saturation and clears (COUNT_WIDTH=2): 5 sbit words -> sbit_cnt=3. Then cnt_clr coincident with a 6th sbit word -> counter 0. Then log_clr coincident with a new dbit word -> log holds the new tag.
6. Bypass and reset: bypassed word with in_data=54'h1, parity 0 -> out_data=1, flags 0, no count. Assert rst with both stages full -> out_valid=0 and counters/log cleared next cycle, in_ready=1 after release.
